// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, receive states and byte helpers for the PS/2 key path
package ps2_pkg;

    localparam int PS2_KEY_W = 11;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_REL    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    // Pause skips the remaining seven bytes of its fixed sequence
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Keyboard housekeeping bytes that never describe a key
    function automatic logic is_discard(input logic [7:0] b);
        return (b == PS2_BAT)    || (b == PS2_ACK)  || (b == PS2_RESEND) ||
               (b == PS2_ECHO)   || (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - line conditioning and 11-bit PS/2 device-to-host frame receiver
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 12000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int FILT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

    logic              clk_s1, clk_s2;
    logic              dat_s1, dat_s2;
    logic              filt_clk, filt_clk_d;
    logic [FILT_W-1:0] filt_cnt;
    logic              fall_stb;

    rx_state_t         state, state_n;
    logic [2:0]        bit_cnt, bit_cnt_n;
    logic [7:0]        shift, shift_n;
    logic              par_err, par_err_n;
    logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_n;
    logic              byte_valid_n, frame_err_n;

    // Two-flop synchronisers; idle PS/2 lines are high
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Clock filter: level follows only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            filt_clk_d <= filt_clk;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall_stb = filt_clk_d & ~filt_clk;

    // Receive FSM state and datapath registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par_err    <= 1'b0;
            tmo_cnt    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            par_err    <= par_err_n;
            tmo_cnt    <= tmo_cnt_n;
            byte_valid <= byte_valid_n;
            frame_err  <= frame_err_n;
        end
    end

    // Next-state logic: advance on each filtered falling edge, abort a stalled frame
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        par_err_n    = par_err;
        tmo_cnt_n    = (state == RX_IDLE) ? '0 : tmo_cnt + 1'b1;
        byte_valid_n = 1'b0;
        frame_err_n  = 1'b0;

        if (fall_stb) begin
            tmo_cnt_n = '0;
            case (state)
                RX_IDLE: begin
                    if (!dat_s2) begin
                        state_n   = RX_DATA;
                        bit_cnt_n = '0;
                    end
                end
                RX_DATA: begin
                    shift_n   = {dat_s2, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    // Odd parity: data plus parity bit must hold an odd number of ones
                    par_err_n = ~(^{shift, dat_s2});
                    state_n   = RX_STOP;
                end
                RX_STOP: begin
                    if (dat_s2 && !par_err) begin
                        byte_valid_n = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                    state_n = RX_IDLE;
                end
                default: state_n = RX_IDLE;
            endcase
        end else if (state != RX_IDLE && tmo_cnt == TMO_LAST) begin
            frame_err_n = 1'b1;
            state_n     = RX_IDLE;
            tmo_cnt_n   = '0;
        end
    end

    assign rx_byte = shift;

endmodule

// File: rtl/ps2_key_encoder.sv
// rtl/ps2_key_encoder.sv - PS/2 prefix decoder producing the toggle-style 11-bit key word
module ps2_key_encoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 12000
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    output logic [PS2_KEY_W-1:0] ps2_key,
    output logic                 byte_valid,
    output logic                 frame_err
);

    logic [7:0] rx_byte;
    logic       ext;
    logic       rel;
    logic [2:0] skip_cnt;

    ps2_frame_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    // Prefix/skip decoder; a broken frame drops any half-built prefix sequence
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ps2_key  <= '0;
            ext      <= 1'b0;
            rel      <= 1'b0;
            skip_cnt <= '0;
        end else if (frame_err) begin
            ext      <= 1'b0;
            rel      <= 1'b0;
            skip_cnt <= '0;
        end else if (byte_valid) begin
            if (skip_cnt != 3'd0) begin
                skip_cnt <= skip_cnt - 3'd1;
            end else if (rx_byte == PS2_PAUSE) begin
                skip_cnt <= PS2_PAUSE_SKIP;
            end else if (rx_byte == PS2_EXT) begin
                ext <= 1'b1;
            end else if (rx_byte == PS2_REL) begin
                rel <= 1'b1;
            end else if (is_discard(rx_byte)) begin
                ext <= 1'b0;
                rel <= 1'b0;
            end else begin
                ps2_key <= {~ps2_key[PS2_KEY_W-1], ~rel, ext, rx_byte};
                ext     <= 1'b0;
                rel     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// tb/tb_ps2_key_encoder.sv - directed self-checking bench for ps2_key_encoder
module tb_ps2_key_encoder;

    localparam int HALF = 20;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        byte_valid;
    logic        frame_err;

    int tests = 0;
    int failures = 0;

    int cyc = 0;
    int bv_cnt = 0;
    int fe_cnt = 0;
    int bv_cyc = 0;
    int key_cyc = 0;
    logic [10:0] key_prev = '0;

    ps2_key_encoder #(
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (12000)
    ) u_dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ps2_key    (ps2_key),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    // Pulse counters and change timestamps, sampled away from the active edge
    always @(negedge clk_sys) begin
        cyc = cyc + 1;
        if (byte_valid) begin
            bv_cnt = bv_cnt + 1;
            bv_cyc = cyc;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (ps2_key !== key_prev) key_cyc = cyc;
        key_prev = ps2_key;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        idle(HALF);
        ps2_clk = 1'b0;
        idle(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(bad_par ? (^b) : ~(^b));
        ps2_bit(1'b1);
        ps2_data = 1'b1;
    endtask

    task automatic send_key(input logic [7:0] b);
        send_frame(b, 1'b0);
        idle(40);
    endtask

    task automatic check_key(input string name, input logic [10:0] exp);
        tests++;
        if (ps2_key !== exp) begin
            failures++;
            $display("FAIL %s: ps2_key=%h expected %h", name, ps2_key, exp);
        end
    endtask

    task automatic check_cnt(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: count=%0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(5);
        tests++;
        if (ps2_key !== 11'h000 || byte_valid !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: key=%h bv=%b fe=%b expected 000 0 0", ps2_key, byte_valid, frame_err);
        end
        reset = 1'b0;
        idle(20);
    endtask

    task automatic test_make();
        int bv0 = bv_cnt;
        send_key(8'h1C);
        check_key("make_1c", 11'h61C);
        check_cnt("make_bv_once", bv_cnt - bv0, 1);
        check_cnt("key_latency", key_cyc - bv_cyc, 1);
    endtask

    task automatic test_release();
        send_key(8'hF0);
        check_key("f0_alone_no_change", 11'h61C);
        send_key(8'h1C);
        check_key("break_1c", 11'h01C);
    endtask

    task automatic test_extended();
        send_key(8'hE0);
        send_key(8'h75);
        check_key("ext_make_75", 11'h775);
        send_key(8'hE0);
        send_key(8'hF0);
        send_key(8'h75);
        check_key("ext_break_e0f0", 11'h175);
        send_key(8'hF0);
        send_key(8'hE0);
        send_key(8'h75);
        check_key("ext_break_f0e0", 11'h575);
    endtask

    task automatic test_parity_error();
        int bv0 = bv_cnt;
        int fe0 = fe_cnt;
        send_frame(8'h29, 1'b1);
        idle(40);
        check_cnt("parity_frame_err", fe_cnt - fe0, 1);
        check_cnt("parity_no_byte", bv_cnt - bv0, 0);
        check_key("parity_key_held", 11'h575);
        send_key(8'h29);
        check_key("after_parity_29", 11'h229);
    endtask

    task automatic test_timeout();
        int bv0 = bv_cnt;
        int fe0 = fe_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        idle(13000);
        check_cnt("timeout_one_err", fe_cnt - fe0, 1);
        check_cnt("timeout_no_byte", bv_cnt - bv0, 0);
        send_key(8'h1C);
        check_key("after_timeout_1c", 11'h61C);
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [10] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0,
                                 8'h14, 8'hF0, 8'h77, 8'hAA, 8'hFA};
        int bv0 = bv_cnt;
        int fe0 = fe_cnt;
        for (int i = 0; i < 10; i++) send_frame(seq[i], 1'b0);
        idle(40);
        check_key("pause_discard_held", 11'h61C);
        check_cnt("b2b_bytes", bv_cnt - bv0, 10);
        check_cnt("b2b_no_err", fe_cnt - fe0, 0);
        send_key(8'h16);
        check_key("after_pause_16", 11'h216);
    endtask

    task automatic test_reset_mid_frame();
        int bv0;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        reset = 1'b1;
        idle(2);
        tests++;
        if (ps2_key !== 11'h000 || byte_valid !== 1'b0 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs: key=%h bv=%b fe=%b expected 000 0 0", ps2_key, byte_valid, frame_err);
        end
        reset = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        idle(30);
        bv0 = bv_cnt;
        send_key(8'h1C);
        check_key("midreset_1c", 11'h61C);
        check_cnt("midreset_bv", bv_cnt - bv0, 1);
    endtask

    initial begin
        test_reset();
        test_make();
        test_release();
        test_extended();
        test_parity_error();
        test_timeout();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
